// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_MAX_WAIT = 15;
  localparam int DEF_CNT_W    = 8;

  // Bubble instruction (addi x0,x0,0) that IF/ID holds after a flush.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts cycles spent waiting for imem_ack and flags the last permitted one.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] wait_cnt;

  // Wait counter: clear has priority over count.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (wait_cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC/IF-ID control, stall/redirect arbitration,
// redirect holding across an in-flight fetch, and hung-memory detection.
//
// state | meaning
// BOOT  | one cycle after reset, IF/ID flushed, no request
// FETCH | request outstanding for current PC
// HOLD  | fetched data refused by ID stall; PC re-fetched on exit
// ERROR | memory timed out; only reset leaves
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_ID,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] PC_Branch,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic              PC_write,
  output logic              PCSrc,
  output logic [ADDR_W-1:0] PC_Branch_IF,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              fetch_valid,
  output logic              imem_err
);

  fetch_state_t      state, state_nxt;
  logic              pend, pend_nxt;
  logic [ADDR_W-1:0] tgt_q, tgt_nxt;
  logic              cnt_clr, cnt_en, timeout, to_err;

  fetch_wait_timer #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .timeout(timeout)
  );

  // An older held redirect always wins over whatever EX presents now.
  assign PC_Branch_IF = pend ? tgt_q : PC_Branch;

  // State, redirect latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pend        <= 1'b0;
      tgt_q       <= '0;
      fetch_valid <= 1'b0;
      imem_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      tgt_q <= tgt_nxt;
      if (IF_ID_flush) begin
        fetch_valid <= 1'b0;
      end else if (IF_ID_write) begin
        fetch_valid <= 1'b1;
      end
      if (to_err) begin
        imem_err <= 1'b1;
      end
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend;
    tgt_nxt     = tgt_q;
    imem_req    = 1'b0;
    PC_write    = 1'b0;
    PCSrc       = 1'b0;
    IF_ID_write = 1'b0;
    IF_ID_flush = 1'b0;
    cnt_clr     = 1'b1;
    cnt_en      = 1'b0;
    to_err      = 1'b0;
    case (state)
      BOOT: begin
        IF_ID_flush = 1'b1;
        state_nxt   = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        cnt_clr  = 1'b0;
        if (!imem_ack) begin
          if (branch_taken && !pend) begin
            pend_nxt    = 1'b1;
            tgt_nxt     = PC_Branch;
            IF_ID_flush = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
          if (timeout) begin
            state_nxt = ERROR;
            to_err    = 1'b1;
          end
        end else begin
          cnt_clr = 1'b1;
          if (pend || branch_taken) begin
            // Data belongs to the squashed path: drop it and redirect.
            IF_ID_flush = 1'b1;
            PC_write    = 1'b1;
            PCSrc       = 1'b1;
            pend_nxt    = 1'b0;
          end else if (stall_ID) begin
            state_nxt = HOLD;
          end else begin
            PC_write    = 1'b1;
            IF_ID_write = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pend_nxt    = 1'b1;
          tgt_nxt     = PC_Branch;
          IF_ID_flush = 1'b1;
          state_nxt   = FETCH;
        end else if (!stall_ID) begin
          state_nxt = FETCH;
        end
      end
      ERROR: begin
        IF_ID_flush = 1'b1;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl with a PC-level reference model.
module tb_fetch_ctrl;

  localparam int AW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset, stall_ID, branch_taken, imem_ack;
  logic [AW-1:0] PC_Branch;
  logic          imem_req, PC_write, PCSrc, IF_ID_write, IF_ID_flush;
  logic          fetch_valid, imem_err;
  logic [AW-1:0] PC_Branch_IF;

  int checks = 0;
  int errors = 0;

  // Reference model: a program counter plus the pending-redirect queue.
  bit            m_boot, m_hold, m_dead, m_fv, m_err;
  int            m_wait;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_redir[$];

  fetch_ctrl #(.ADDR_W(AW), .MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_ID    (stall_ID),
    .branch_taken(branch_taken),
    .PC_Branch   (PC_Branch),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .PC_write    (PC_write),
    .PCSrc       (PCSrc),
    .PC_Branch_IF(PC_Branch_IF),
    .IF_ID_write (IF_ID_write),
    .IF_ID_flush (IF_ID_flush),
    .fetch_valid (fetch_valid),
    .imem_err    (imem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_boot = 1; m_hold = 0; m_dead = 0; m_fv = 0; m_err = 0;
    m_wait = 0; m_pc = 32'h0000_1000;
    m_redir.delete();
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic step(input bit rst, input bit st, input bit br, input bit ack,
                      input logic [AW-1:0] tgt);
    bit e_req, e_pcw, e_iw, e_fl, n_err;
    logic [AW-1:0] e_bif, dut_pc;
    @(negedge clk);
    reset = rst; stall_ID = st; branch_taken = br; imem_ack = ack; PC_Branch = tgt;
    #1;
    if (rst) begin
      model_init();
    end else begin
      e_req = 0; e_pcw = 0; e_iw = 0; e_fl = 0; n_err = m_err;
      e_bif = (m_redir.size() != 0) ? m_redir[0] : tgt;
      chk("fetch_valid", fetch_valid, m_fv);
      chk("imem_err", imem_err, m_err);
      chk("PC_Branch_IF", PC_Branch_IF, e_bif);
      dut_pc = PC_write ? (PCSrc ? PC_Branch_IF : m_pc + 4) : m_pc;
      if (m_dead) begin
        e_fl = 1;
      end else if (m_boot) begin
        e_fl = 1; m_boot = 0;
      end else if (m_hold) begin
        if (br) begin
          m_redir.push_back(tgt); e_fl = 1; m_hold = 0;
        end else if (!st) begin
          m_hold = 0;
        end
      end else begin
        e_req = 1;
        if (!ack) begin
          if (m_wait == MW - 1) begin
            m_dead = 1; n_err = 1;
          end
          if (br && m_redir.size() == 0) begin
            m_redir.push_back(tgt); e_fl = 1;
          end else begin
            m_wait++;
          end
        end else if (m_redir.size() != 0 || br) begin
          m_pc = (m_redir.size() != 0) ? m_redir.pop_front() : tgt;
          e_pcw = 1; e_fl = 1;
        end else if (st) begin
          m_hold = 1;
        end else begin
          m_pc = m_pc + 4; e_pcw = 1; e_iw = 1;
        end
      end
      if (m_dead || m_hold || ack) m_wait = 0;
      chk("imem_req", imem_req, e_req);
      chk("PC_write", PC_write, e_pcw);
      chk("IF_ID_write", IF_ID_write, e_iw);
      chk("IF_ID_flush", IF_ID_flush, e_fl);
      chk("pc_next", dut_pc, m_pc);
      m_pc = dut_pc;
      if (e_fl) m_fv = 0;
      else if (e_iw) m_fv = 1;
      m_err = n_err;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
  endtask

  initial begin
    bit st, br, ack;
    reset = 1; stall_ID = 0; branch_taken = 0; imem_ack = 0; PC_Branch = '0;
    // 1: ack every cycle
    do_reset();
    step(0, 0, 1, 1, 32'h44);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    // 2: ack after 3 wait cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    // 3: redirect arrives two cycles before ack
    step(0, 0, 1, 0, 32'h40);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t3_pc", m_pc, 32'h40);
    // 4: younger redirect ignored while one is held
    step(0, 0, 1, 0, 32'h40);
    step(0, 0, 1, 0, 32'h80);
    step(0, 0, 0, 1, 32'h90);
    chk("t4_pc", m_pc, 32'h40);
    // 5: stall into HOLD, then branch while still stalled
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 32'h100);
    step(0, 1, 0, 1, 0);
    chk("t5_pc", m_pc, 32'h100);
    // 6: timeout into ERROR, then recovery by reset
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h200);
    chk("t6_err", imem_err, 1'b1);
    do_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Randomized traffic, re-reset periodically so ERROR does not dominate
    for (int blk = 0; blk < 20; blk++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        st  = ($urandom_range(3) == 0);
        br  = ($urandom_range(6) == 0);
        ack = ($urandom_range(9) < 6);
        step(0, st, br, ack, $urandom & 32'hFFFF_FFFC);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
